// File: rtl/tuple_pkg.sv
// Shared types and constants for the {x, y} product stream.
package tuple_pkg;

  localparam int unsigned X_WIDTH  = 8;
  localparam int unsigned Y_WIDTH  = 4;
  localparam int unsigned XY_WIDTH = X_WIDTH + Y_WIDTH;

  localparam logic [X_WIDTH-1:0] INIT_X = 8'hde;
  localparam logic [Y_WIDTH-1:0] INIT_Y = 4'ha;

  // Packed order is {y, x}, so x occupies the LSBs, matching the downstream register.
  typedef struct packed {
    logic [Y_WIDTH-1:0] y;
    logic [X_WIDTH-1:0] x;
  } xy_t;

  localparam xy_t XY_INIT = '{y: INIT_Y, x: INIT_X};

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/tuple_slot_reg.sv
// One storage slot of the skid buffer: load-enabled register with async-low reset to INIT.
module tuple_slot_reg
  import tuple_pkg::*;
#(
  parameter int unsigned    W    = XY_WIDTH,
  parameter logic [W-1:0]   INIT = XY_INIT
) (
  input  logic         CLK,
  input  logic         ASYNCRESETN,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  // Capture i_d when loaded; reset returns the slot to its initial value.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_q <= INIT;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/tuple_skid_buffer.sv
// Two-entry ready/valid skid buffer for the {x, y} product stream.
// I_ready and O_valid depend only on registered state, so no combinational
// ready path crosses the stage.
module tuple_skid_buffer
  import tuple_pkg::*;
#(
  parameter int unsigned          X_WIDTH = tuple_pkg::X_WIDTH,
  parameter int unsigned          Y_WIDTH = tuple_pkg::Y_WIDTH,
  parameter logic [X_WIDTH-1:0]   INIT_X  = tuple_pkg::INIT_X,
  parameter logic [Y_WIDTH-1:0]   INIT_Y  = tuple_pkg::INIT_Y
) (
  input  logic               CLK,
  input  logic               ASYNCRESETN,
  input  logic [X_WIDTH-1:0] I_x,
  input  logic [Y_WIDTH-1:0] I_y,
  input  logic               I_valid,
  output logic               I_ready,
  output logic [X_WIDTH-1:0] O_x,
  output logic [Y_WIDTH-1:0] O_y,
  output logic               O_valid,
  input  logic               O_ready,
  output logic [1:0]         COUNT
);

  localparam int unsigned W = X_WIDTH + Y_WIDTH;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_main_load;
  logic           w_main_sel_skid;
  logic           w_skid_load;
  logic [W-1:0]   w_in_packed;
  logic [W-1:0]   w_main_d;
  logic [W-1:0]   w_main_q;
  logic [W-1:0]   w_skid_q;

  assign I_ready     = (r_state != FULL);
  assign O_valid     = (r_state != EMPTY);
  assign COUNT       = r_state;
  assign w_in_fire   = I_valid & I_ready;
  assign w_out_fire  = O_valid & O_ready;
  assign w_in_packed = {I_y, I_x};

  // Next-state and slot-load decisions for the EMPTY/BUSY/FULL occupancy FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_load     = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_load     = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_in_fire) begin
          w_main_load = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (w_in_fire && w_out_fire) begin
          w_main_load = 1'b1;
        end else if (w_in_fire) begin
          w_skid_load = 1'b1;
          w_state_nxt = FULL;
        end else if (w_out_fire) begin
          w_state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (w_out_fire) begin
          w_main_load     = 1'b1;
          w_main_sel_skid = 1'b1;
          w_state_nxt     = BUSY;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q : w_in_packed;

  // Occupancy state register.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  tuple_slot_reg #(
    .W    (W),
    .INIT ({INIT_Y, INIT_X})
  ) u_main (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .i_load      (w_main_load),
    .i_d         (w_main_d),
    .o_q         (w_main_q)
  );

  tuple_slot_reg #(
    .W    (W),
    .INIT ({INIT_Y, INIT_X})
  ) u_skid (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .i_load      (w_skid_load),
    .i_d         (w_in_packed),
    .o_q         (w_skid_q)
  );

  // Outputs always come from the main slot.
  assign O_x = w_main_q[X_WIDTH-1:0];
  assign O_y = w_main_q[W-1:X_WIDTH];

endmodule

// File: tb/tb_tuple_skid_buffer.sv
// Directed self-checking bench for tuple_skid_buffer.
module tb_tuple_skid_buffer;

  logic       CLK = 1'b0;
  logic       ASYNCRESETN = 1'b0;
  logic [7:0] I_x = '0;
  logic [3:0] I_y = '0;
  logic       I_valid = 1'b0;
  logic       I_ready;
  logic [7:0] O_x;
  logic [3:0] O_y;
  logic       O_valid;
  logic       O_ready = 1'b0;
  logic [1:0] COUNT;

  int total = 0;
  int bad   = 0;

  tuple_skid_buffer #(
    .X_WIDTH (8),
    .Y_WIDTH (4),
    .INIT_X  (8'hde),
    .INIT_Y  (4'ha)
  ) dut (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .I_x         (I_x),
    .I_y         (I_y),
    .I_valid     (I_valid),
    .I_ready     (I_ready),
    .O_x         (O_x),
    .O_y         (O_y),
    .O_valid     (O_valid),
    .O_ready     (O_ready),
    .COUNT       (COUNT)
  );

  always #5 CLK = ~CLK;

  // Advance one active edge and settle before sampling.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    // Put something in the buffer, then reset mid-cycle with no clock edge.
    #2;
    ASYNCRESETN = 1'b1;
    tick();
    O_ready = 1'b0; I_valid = 1'b1; I_x = 8'h5a; I_y = 4'h7;
    tick();
    I_valid = 1'b0;
    total++; if (O_x !== 8'h5a || O_valid !== 1'b1) begin bad++; $display("FAIL rst_preload got x=%h v=%b exp x=5a v=1", O_x, O_valid); end
    @(negedge CLK); #1;
    ASYNCRESETN = 1'b0;
    #1;
    total++; if (O_valid !== 1'b0) begin bad++; $display("FAIL rst_ovalid got=%b exp=0", O_valid); end
    total++; if (I_ready !== 1'b1) begin bad++; $display("FAIL rst_iready got=%b exp=1", I_ready); end
    total++; if (COUNT !== 2'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", COUNT); end
    total++; if (O_x !== 8'hde) begin bad++; $display("FAIL rst_ox got=%h exp=de", O_x); end
    total++; if (O_y !== 4'ha) begin bad++; $display("FAIL rst_oy got=%h exp=a", O_y); end
    #1;
    ASYNCRESETN = 1'b1;
    tick();
  endtask

  task automatic test_pass_through();
    O_ready = 1'b1; I_valid = 1'b1; I_x = 8'h01; I_y = 4'h1;
    tick();
    total++; if (O_valid !== 1'b1 || O_x !== 8'h01 || O_y !== 4'h1) begin bad++; $display("FAIL pt_item1 got v=%b x=%h y=%h exp v=1 x=01 y=1", O_valid, O_x, O_y); end
    total++; if (COUNT !== 2'd1 || I_ready !== 1'b1) begin bad++; $display("FAIL pt_count1 got c=%0d r=%b exp c=1 r=1", COUNT, I_ready); end
    I_x = 8'h02; I_y = 4'h2;
    tick();
    total++; if (O_valid !== 1'b1 || O_x !== 8'h02 || O_y !== 4'h2) begin bad++; $display("FAIL pt_item2 got v=%b x=%h y=%h exp v=1 x=02 y=2", O_valid, O_x, O_y); end
    total++; if (COUNT !== 2'd1) begin bad++; $display("FAIL pt_count2 got=%0d exp=1", COUNT); end
    I_valid = 1'b0;
    tick();
    total++; if (O_valid !== 1'b0 || COUNT !== 2'd0 || O_x !== 8'h02) begin bad++; $display("FAIL pt_empty got v=%b c=%0d x=%h exp v=0 c=0 x=02", O_valid, COUNT, O_x); end
  endtask

  task automatic test_backpressure();
    O_ready = 1'b0; I_valid = 1'b1; I_x = 8'h11; I_y = 4'h3;
    tick();
    total++; if (COUNT !== 2'd1 || O_x !== 8'h11 || O_y !== 4'h3) begin bad++; $display("FAIL bp_first got c=%0d x=%h y=%h exp c=1 x=11 y=3", COUNT, O_x, O_y); end
    I_x = 8'h22; I_y = 4'h4;
    tick();
    total++; if (COUNT !== 2'd2 || I_ready !== 1'b0) begin bad++; $display("FAIL bp_full got c=%0d r=%b exp c=2 r=0", COUNT, I_ready); end
    total++; if (O_x !== 8'h11 || O_y !== 4'h3 || O_valid !== 1'b1) begin bad++; $display("FAIL bp_hold1 got x=%h y=%h v=%b exp x=11 y=3 v=1", O_x, O_y, O_valid); end
    I_x = 8'h33; I_y = 4'h5;
    tick();
    total++; if (COUNT !== 2'd2 || O_x !== 8'h11 || O_y !== 4'h3) begin bad++; $display("FAIL bp_reject got c=%0d x=%h y=%h exp c=2 x=11 y=3", COUNT, O_x, O_y); end
  endtask

  task automatic test_drain();
    // Third item (33,5) is still held on the input from the previous task.
    O_ready = 1'b1;
    tick();
    total++; if (O_x !== 8'h22 || O_y !== 4'h4 || COUNT !== 2'd1 || I_ready !== 1'b1) begin bad++; $display("FAIL dr_second got x=%h y=%h c=%0d r=%b exp x=22 y=4 c=1 r=1", O_x, O_y, COUNT, I_ready); end
    tick();
    I_valid = 1'b0;
    total++; if (O_x !== 8'h33 || O_y !== 4'h5 || COUNT !== 2'd1) begin bad++; $display("FAIL dr_third got x=%h y=%h c=%0d exp x=33 y=5 c=1", O_x, O_y, COUNT); end
    tick();
    total++; if (COUNT !== 2'd0 || O_valid !== 1'b0) begin bad++; $display("FAIL dr_empty got c=%0d v=%b exp c=0 v=0", COUNT, O_valid); end
  endtask

  task automatic test_simultaneous();
    O_ready = 1'b0; I_valid = 1'b1; I_x = 8'h44; I_y = 4'h6;
    tick();
    total++; if (O_x !== 8'h44 || COUNT !== 2'd1) begin bad++; $display("FAIL sim_load got x=%h c=%0d exp x=44 c=1", O_x, COUNT); end
    O_ready = 1'b1; I_x = 8'h55; I_y = 4'h7;
    tick();
    total++; if (O_x !== 8'h55 || O_y !== 4'h7 || COUNT !== 2'd1 || O_valid !== 1'b1) begin bad++; $display("FAIL sim_swap got x=%h y=%h c=%0d v=%b exp x=55 y=7 c=1 v=1", O_x, O_y, COUNT, O_valid); end
    I_valid = 1'b0;
    tick();
    total++; if (COUNT !== 2'd0 || O_valid !== 1'b0) begin bad++; $display("FAIL sim_empty got c=%0d v=%b exp c=0 v=0", COUNT, O_valid); end
  endtask

  task automatic test_reset_full();
    O_ready = 1'b0; I_valid = 1'b1; I_x = 8'h66; I_y = 4'h8;
    tick();
    I_x = 8'h77; I_y = 4'h9;
    tick();
    I_valid = 1'b0;
    total++; if (COUNT !== 2'd2) begin bad++; $display("FAIL rf_full got=%0d exp=2", COUNT); end
    @(negedge CLK); #1;
    ASYNCRESETN = 1'b0;
    #1;
    total++; if (COUNT !== 2'd0 || O_valid !== 1'b0 || I_ready !== 1'b1) begin bad++; $display("FAIL rf_state got c=%0d v=%b r=%b exp c=0 v=0 r=1", COUNT, O_valid, I_ready); end
    total++; if (O_x !== 8'hde || O_y !== 4'ha) begin bad++; $display("FAIL rf_init got x=%h y=%h exp x=de y=a", O_x, O_y); end
    #1;
    ASYNCRESETN = 1'b1;
    tick();
    total++; if (COUNT !== 2'd0 || O_valid !== 1'b0) begin bad++; $display("FAIL rf_after got c=%0d v=%b exp c=0 v=0", COUNT, O_valid); end
    I_valid = 1'b1; I_x = 8'haa; I_y = 4'hb;
    tick();
    I_x = 8'hbb; I_y = 4'hc;
    tick();
    I_valid = 1'b0;
    total++; if (O_x !== 8'haa || O_y !== 4'hb || COUNT !== 2'd2) begin bad++; $display("FAIL rf_first got x=%h y=%h c=%0d exp x=aa y=b c=2", O_x, O_y, COUNT); end
    O_ready = 1'b1;
    tick();
    total++; if (O_x !== 8'hbb || O_y !== 4'hc || COUNT !== 2'd1) begin bad++; $display("FAIL rf_second got x=%h y=%h c=%0d exp x=bb y=c c=1", O_x, O_y, COUNT); end
    tick();
    total++; if (COUNT !== 2'd0 || O_valid !== 1'b0) begin bad++; $display("FAIL rf_drain got c=%0d v=%b exp c=0 v=0", COUNT, O_valid); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_backpressure();
    test_drain();
    test_simultaneous();
    test_reset_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
